flag_stack_register: RTL and testbench
======================================

// Module: flag_stack_register
// PURPOSE
//   Parametrised condition-flag register for the execute/memory stage, with per-flag write enables
//   and a LIFO save/restore stack for interrupt entry and RTI.
//   Holds the architectural flags (default Z,N,C) read by the branch unit.
//   Saves them on interrupt entry and restores them on return, nesting up to DEPTH levels.
// PARAMETERS
//   FLAG_W  3  number of flag bits (bit0=C, bit1=N, bit2=Z at default width)
//   DEPTH   4  save-stack entries (>=2, power of two)
// PORTS
//   i_clk        in   1                  clock; all state updates on posedge
//   i_rst_n      in   1                  asynchronous reset, active-low
//   i_flags      in   FLAG_W             new flag values from ALU
//   i_wr_mask    in   FLAG_W             per-bit write enable for i_flags
//   i_save       in   1                  push current o_flags (interrupt entry)
//   i_restore    in   1                  pop top entry into o_flags (RTI)
//   i_err_clr    in   1                  clear sticky error bits
//   o_flags      out  FLAG_W             architectural flags
//   o_depth      out  $clog2(DEPTH)+1    valid stack entries, 0..DEPTH
//   o_empty      out  1                  o_depth==0
//   o_full       out  1                  o_depth==DEPTH
//   o_overflow   out  1                  sticky: save while full (dropped)
//   o_underflow  out  1                  sticky: restore while empty
// BEHAVIOUR
// - Reset (async, i_rst_n=0): o_flags=0, o_depth=0, o_overflow=0, o_underflow=0, stack contents cleared.
//   Reset mid-nest discards all entries.
// - Write only: o_flags[i] <= i_wr_mask[i] ? i_flags[i] : o_flags[i]. Visible 1 cycle after the edge.
// - Save only, not full:
//   - stack[depth] <= pre-write o_flags (value before this edge); depth+1.
//   - The masked write still applies to o_flags in the same cycle.
// - Restore only, not empty:
//   - o_flags <= stack[depth-1]; depth-1.
//   - Restore overrides any masked write in the same cycle.
// - Save+restore same cycle, not empty (full included) = swap:
//   - stack[depth-1] <= pre-write o_flags; o_flags <= old stack[depth-1].
//   - depth unchanged; no error.
// - Restore while empty:
//   - o_underflow <= 1; o_flags takes the masked write only.
//   - A simultaneous save is performed normally (depth 0->1).
// - Save while full (no restore): see CONFIGURATION.
// - i_err_clr clears both sticky bits.
//   - A new error on the same edge wins: the bit stays 1.
// - o_empty and o_full are decoded combinationally from the depth register (no extra latency).
// - No X propagation: unused stack slots read as 0.
// CONFIGURATION
// - Macro FLAG_STACK_WRAP_EN.
// - Defined:
//   - The stack is circular.
//   - Save while full overwrites the oldest entry; depth stays DEPTH.
//   - o_overflow is never set; the restore order still returns the newest DEPTH entries.
// - Undefined:
//   - Save while full is dropped; contents and depth are unchanged.
//   - o_overflow <= 1.
// TESTING
// 1 Reset then mask=3'b101, flags=3'b111 -> o_flags=3'b101; mask=0 -> o_flags holds 3'b101.
// 2 Nest: set flags A=3'b001, save; B=3'b010, save; C=3'b100
//   -> restore yields 3'b010 then 3'b001, depth 2->1->0, o_empty=1.
// 3 Save+restore same cycle at depth 1, o_flags=3'b110, top=3'b011
//   -> o_flags=3'b011, top=3'b110, depth=1.
// 4 Restore at depth 0 -> o_underflow=1, o_flags unchanged.
//   i_err_clr -> o_underflow=0.
// 5 DEPTH+1 saves of 1..5 (DEPTH=4):
//   - without macro: o_overflow=1, pops return 4,3,2,1;
//   - with FLAG_STACK_WRAP_EN: no overflow, pops return 5,4,3,2.
// 6 Assert i_rst_n low mid-cycle at depth 3 -> outputs 0 immediately (async), o_empty=1.

Source files
------------

// File: rtl/flag_stack_register.sv
// Condition-flag register with per-bit write enables and a LIFO save/restore stack for interrupt nesting.
// Optional build macro FLAG_STACK_WRAP_EN: save while full overwrites the oldest entry instead of being dropped.
module flag_stack_register #(
  parameter int FLAG_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [FLAG_W-1:0]          i_flags,
  input  logic [FLAG_W-1:0]          i_wr_mask,
  input  logic                       i_save,
  input  logic                       i_restore,
  input  logic                       i_err_clr,
  output logic [FLAG_W-1:0]          o_flags,
  output logic [$clog2(DEPTH):0]     o_depth,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [FLAG_W-1:0] stack_q [DEPTH];
  logic [FLAG_W-1:0] stack_d [DEPTH];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              empty, full;
  logic [AW-1:0]     top_idx, push_idx;
  logic [DW-1:0]     depth_m1;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DW'(DEPTH));
  assign depth_m1 = depth_q - DW'(1);
  assign top_idx  = depth_m1[AW-1:0];
  // push_idx wraps to 0 when full, but it is only used when not full
  assign push_idx = depth_q[AW-1:0];

  always_comb begin
    flags_d = (flags_q & ~i_wr_mask) | (i_flags & i_wr_mask);
    depth_d = depth_q;
    stack_d = stack_q;
    ovf_d   = ovf_q & ~i_err_clr;
    unf_d   = unf_q & ~i_err_clr;

    if (i_restore && empty) begin
      unf_d = 1'b1;
    end

    if (i_save && i_restore && !empty) begin
      stack_d[top_idx] = flags_q;
      flags_d          = stack_q[top_idx];
    end else if (i_restore && !empty) begin
      flags_d          = stack_q[top_idx];
      stack_d[top_idx] = '0;
      depth_d          = depth_m1;
    end else if (i_save) begin
      if (!full) begin
        stack_d[push_idx] = flags_q;
        depth_d           = depth_q + DW'(1);
      end else begin
`ifdef FLAG_STACK_WRAP_EN
        // Shift out the oldest entry so the newest DEPTH saves stay in LIFO order
        for (int i = 0; i < DEPTH - 1; i++) begin
          stack_d[i] = stack_q[i+1];
        end
        stack_d[DEPTH-1] = flags_q;
`else
        ovf_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flags_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign o_flags     = flags_q;
  assign o_depth     = depth_q;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_flag_stack_register.sv
// Self-checking bench for flag_stack_register: vector table, corner sequences, randomized run vs queue model.
module tb_flag_stack_register;

  localparam int FLAG_W = 3;
  localparam int DEPTH  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [FLAG_W-1:0] flags, mask;
  logic             save, restore, err_clr;
  logic [FLAG_W-1:0] o_flags;
  logic [2:0]       o_depth;
  logic             o_empty, o_full, o_overflow, o_underflow;

  int checks = 0;
  int failures = 0;

  flag_stack_register #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flags(flags), .i_wr_mask(mask),
    .i_save(save), .i_restore(restore), .i_err_clr(err_clr),
    .o_flags(o_flags), .o_depth(o_depth), .o_empty(o_empty), .o_full(o_full),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;
    logic [2:0] mask;
    logic       save;
    logic       restore;
    logic       clr;
    logic [2:0] exp_flags;
    int         exp_depth;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t vecs [13];

  // Reference model state
  logic [2:0] m_flags;
  logic [2:0] m_q[$];
  logic       m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] ef, input int ed,
                         input logic eo, input logic eu);
    chk({name, ".flags"}, int'(o_flags), int'(ef));
    chk({name, ".depth"}, int'(o_depth), ed);
    chk({name, ".empty"}, int'(o_empty), int'(ed == 0));
    chk({name, ".full"}, int'(o_full), int'(ed == DEPTH));
    chk({name, ".ovf"}, int'(o_overflow), int'(eo));
    chk({name, ".unf"}, int'(o_underflow), int'(eu));
  endtask

  task automatic drive(input logic [2:0] f, input logic [2:0] m, input logic s,
                       input logic r, input logic c);
    flags = f; mask = m; save = s; restore = r; err_clr = c;
    @(posedge clk);
    #1;
    flags = '0; mask = '0; save = 0; restore = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flags = '0; mask = '0; save = 0; restore = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: flags plus a queue whose back is the newest saved entry
  task automatic model_step(input logic [2:0] f, input logic [2:0] m, input logic s,
                            input logic r, input logic c);
    logic [2:0] pre, nf, tmp;
    logic new_ovf, new_unf;
    pre = m_flags;
    nf = (pre & ~m) | (f & m);
    new_ovf = 0; new_unf = 0;
    if (r && m_q.size() > 0) begin
      tmp = m_q.pop_back();
      nf = tmp;
      if (s) m_q.push_back(pre);
    end else begin
      if (r) new_unf = 1;
      if (s) begin
        if (m_q.size() < DEPTH) m_q.push_back(pre);
        else begin
`ifdef FLAG_STACK_WRAP_EN
          void'(m_q.pop_front());
          m_q.push_back(pre);
`else
          new_ovf = 1;
`endif
        end
      end
    end
    m_flags = nf;
    m_ovf = (m_ovf & ~c) | new_ovf;
    m_unf = (m_unf & ~c) | new_unf;
  endtask

  initial begin
    //            flags   mask    s  r  c  exp_f   d  ovf unf
    vecs[0]  = '{3'b111, 3'b101, 0, 0, 0, 3'b101, 0, 0, 0};
    vecs[1]  = '{3'b000, 3'b000, 0, 0, 0, 3'b101, 0, 0, 0};
    vecs[2]  = '{3'b011, 3'b111, 0, 0, 0, 3'b011, 0, 0, 0};
    vecs[3]  = '{3'b110, 3'b111, 1, 0, 0, 3'b110, 1, 0, 0};
    vecs[4]  = '{3'b000, 3'b000, 1, 1, 0, 3'b011, 1, 0, 0};
    vecs[5]  = '{3'b000, 3'b000, 0, 1, 0, 3'b110, 0, 0, 0};
    vecs[6]  = '{3'b000, 3'b000, 0, 1, 0, 3'b110, 0, 0, 1};
    vecs[7]  = '{3'b001, 3'b001, 0, 1, 0, 3'b111, 0, 0, 1};
    vecs[8]  = '{3'b000, 3'b000, 0, 0, 1, 3'b111, 0, 0, 0};
    vecs[9]  = '{3'b000, 3'b000, 0, 1, 1, 3'b111, 0, 0, 1};
    vecs[10] = '{3'b000, 3'b000, 1, 1, 1, 3'b111, 1, 0, 1};
    vecs[11] = '{3'b000, 3'b000, 0, 0, 1, 3'b111, 1, 0, 0};
    vecs[12] = '{3'b000, 3'b111, 0, 1, 0, 3'b111, 0, 0, 0};

    rst_n = 1'b0;
    do_reset();
    chk_all("reset", 3'b000, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].flags, vecs[i].mask, vecs[i].save, vecs[i].restore, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_flags, vecs[i].exp_depth,
              vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // Nesting: A saved, B saved, C live; restores return B then A
    do_reset();
    drive(3'b001, 3'b111, 0, 0, 0);
    drive(3'b010, 3'b111, 1, 0, 0);
    drive(3'b100, 3'b111, 1, 0, 0);
    chk_all("nest.pre", 3'b100, 2, 0, 0);
    drive(3'b000, 3'b000, 0, 1, 0);
    chk_all("nest.pop1", 3'b010, 1, 0, 0);
    drive(3'b000, 3'b000, 0, 1, 0);
    chk_all("nest.pop2", 3'b001, 0, 0, 0);

    // DEPTH+1 saves of values 1..5
    do_reset();
    drive(3'd1, 3'b111, 0, 0, 0);
    for (int v = 2; v <= 5; v++) drive(3'(v), 3'b111, 1, 0, 0);
    chk_all("ovf.full", 3'd5, 4, 0, 0);
    drive(3'd0, 3'b000, 1, 0, 0);
`ifdef FLAG_STACK_WRAP_EN
    chk_all("ovf.wrap", 3'd5, 4, 0, 0);
    for (int v = 5; v >= 2; v--) begin
      drive(3'd0, 3'b000, 0, 1, 0);
      chk($sformatf("ovf.pop%0d", v), int'(o_flags), v);
    end
`else
    chk_all("ovf.drop", 3'd5, 4, 1, 0);
    for (int v = 4; v >= 1; v--) begin
      drive(3'd0, 3'b000, 0, 1, 0);
      chk($sformatf("ovf.pop%0d", v), int'(o_flags), v);
    end
`endif
    chk_all("ovf.end", o_flags, 0, o_overflow, 0);
    drive(3'd0, 3'b000, 0, 0, 1);
    chk("ovf.clr", int'(o_overflow), 0);

    // Asynchronous reset mid-nest at depth 3
    drive(3'b111, 3'b111, 1, 0, 0);
    drive(3'b011, 3'b111, 1, 0, 0);
    drive(3'b101, 3'b111, 1, 0, 0);
    chk_all("arst.pre", 3'b101, 3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst.now", 3'b000, 0, 0, 0);
    #1 rst_n = 1'b1;
    drive(3'b000, 3'b000, 0, 1, 0);
    chk_all("arst.pop", 3'b000, 0, 0, 1);

    // Randomized run against the queue model
    do_reset();
    m_flags = '0; m_q.delete(); m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] f, m;
      logic s, r, c;
      f = 3'($urandom);
      m = 3'($urandom);
      s = ($urandom_range(0, 99) < 40);
      r = ($urandom_range(0, 99) < 30);
      c = ($urandom_range(0, 99) < 5);
      model_step(f, m, s, r, c);
      drive(f, m, s, r, c);
      if (n % 10 == 0 || o_flags != m_flags || int'(o_depth) != m_q.size() ||
          o_overflow != m_ovf || o_underflow != m_unf)
        chk_all($sformatf("rnd%0d", n), m_flags, m_q.size(), m_ovf, m_unf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
